// File: rtl/square_cal_pkg.sv
// Shared constants for the square_cal block: operand width default, result width
// derivation and the largest possible square at the default width.
package square_cal_pkg;

   localparam int DEFAULT_WIDTH = 6;

   function automatic int calc_owidth(input int w);
      return 2 * w;
   endfunction

   localparam int DEFAULT_OWIDTH = calc_owidth(DEFAULT_WIDTH);
   localparam int MAX_SQUARE     = 3969;

endpackage

// File: rtl/square_cal_if.sv
// Operand/result bundle of square_cal; the master drives the operand, the slave
// returns the combinational and registered squares.
interface square_cal_if
   import square_cal_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int OWIDTH = calc_owidth(WIDTH)
);

   logic [WIDTH-1:0]  value;
   logic [OWIDTH-1:0] square;
   logic [OWIDTH-1:0] square_q;
   logic              square_q_valid;

   modport master (
      output value,
      input  square,
      input  square_q,
      input  square_q_valid
   );

   modport slave (
      input  value,
      output square,
      output square_q,
      output square_q_valid
   );

endinterface

// File: rtl/square_pp_row.sv
// One partial-product row of the squarer: the operand gated by one of its own bits,
// shifted into position and added to the running sum with a ripple-carry adder.
module square_pp_row
   import square_cal_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int OWIDTH = calc_owidth(WIDTH),
   parameter int ROW    = 1
) (
   input  logic [WIDTH-1:0]  value,
   input  logic              sel,
   input  logic [OWIDTH-1:0] acc_in,
   output logic [OWIDTH-1:0] acc_out
);

   logic [OWIDTH-1:0] pp;
   logic              carry;

   assign pp = OWIDTH'(value & {WIDTH{sel}}) << ROW;

   // The carry out of the top bit is always zero because the full square fits in OWIDTH bits.
   always_comb begin
      carry   = 1'b0;
      acc_out = '0;
      for (int k = 0; k < OWIDTH; k++) begin
         acc_out[k] = acc_in[k] ^ pp[k] ^ carry;
         carry      = (acc_in[k] & pp[k]) | (carry & (acc_in[k] ^ pp[k]));
      end
   end

endmodule

// File: rtl/square_cal.sv
// Unsigned squarer built from an explicit partial-product array, with a registered
// copy of the result and a flag marking it as computed since reset release.
module square_cal
   import square_cal_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int OWIDTH = calc_owidth(WIDTH)
) (
   input  logic       clk,
   input  logic       reset,
   square_cal_if.slave bus
);

   logic [WIDTH-1:0][OWIDTH-1:0] acc;
   logic [OWIDTH-1:0]            square_q;
   logic                         square_q_valid;

   // Row 0 needs no adder; each later row accumulates onto the previous sum.
   assign acc[0] = OWIDTH'(bus.value & {WIDTH{bus.value[0]}});

   for (genvar i = 1; i < WIDTH; i++) begin : g_row
      square_pp_row #(
         .WIDTH  (WIDTH),
         .OWIDTH (OWIDTH),
         .ROW    (i)
      ) u_row (
         .value   (bus.value),
         .sel     (bus.value[i]),
         .acc_in  (acc[i-1]),
         .acc_out (acc[i])
      );
   end

   assign bus.square = acc[WIDTH-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         square_q       <= '0;
         square_q_valid <= 1'b0;
      end else begin
         square_q       <= bus.square;
         square_q_valid <= 1'b1;
      end
   end

   assign bus.square_q       = square_q;
   assign bus.square_q_valid = square_q_valid;

endmodule

// File: tb/tb_square_cal.sv
// Directed bench for square_cal: a vector table for the combinational square, a
// counter sweep with wrap, a mid-sweep reset, and an exhaustive 8-bit sweep.
module tb_square_cal;

   typedef struct {
      logic [5:0]  value;
      logic [11:0] expected;
   } vec_t;

   logic clk;
   logic reset;
   int   tests_run;
   int   tests_failed;

   square_cal_if #(.WIDTH(6)) bus6 ();
   square_cal_if #(.WIDTH(8)) bus8 ();

   square_cal #(.WIDTH(6)) dut6 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus6)
   );

   square_cal #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #50000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic [5:0] v);
      bus6.value = v;
      #1;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      tests_run++;
      if (actual != expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   initial begin
      vec_t        vectors [8];
      logic [5:0]  cnt;
      logic [5:0]  prev;

      vectors[0] = '{6'd0,  12'd0};
      vectors[1] = '{6'd1,  12'd1};
      vectors[2] = '{6'd2,  12'd4};
      vectors[3] = '{6'd63, 12'hF81};
      vectors[4] = '{6'd32, 12'h400};
      vectors[5] = '{6'd45, 12'h7E9};
      vectors[6] = '{6'd7,  12'd49};
      vectors[7] = '{6'd50, 12'd2500};

      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b0;
      bus6.value   = '0;
      bus8.value   = '0;

      // Combinational checks run while reset is held, which also shows square ignores reset.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vectors[i].value);
         checkOutput("table_square", int'(bus6.square), int'(vectors[i].expected));
      end

      checkOutput("reset_square_q", int'(bus6.square_q), 0);
      checkOutput("reset_valid", int'(bus6.square_q_valid), 0);

      #6;
      reset = 1'b1;
      cnt   = 6'd0;
      applyStimulus(cnt);
      checkOutput("sweep_square", int'(bus6.square), 0);

      // 67 edges so the counter passes through 63 -> 0 -> 1 -> 2.
      for (int k = 0; k < 67; k++) begin
         @(posedge clk);
         #1;
         checkOutput("sweep_square_q", int'(bus6.square_q), int'(cnt) * int'(cnt));
         checkOutput("sweep_valid", int'(bus6.square_q_valid), 1);
         prev = cnt;
         cnt  = cnt + 6'd1;
         applyStimulus(cnt);
         checkOutput("sweep_square", int'(bus6.square), int'(cnt) * int'(cnt));
         checkOutput("sweep_square_q_hold", int'(bus6.square_q), int'(prev) * int'(prev));
      end

      reset = 1'b0;
      #1;
      checkOutput("midreset_square_q", int'(bus6.square_q), 0);
      checkOutput("midreset_valid", int'(bus6.square_q_valid), 0);
      applyStimulus(6'd7);
      checkOutput("midreset_square", int'(bus6.square), 49);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("release_preedge_square_q", int'(bus6.square_q), 0);
      checkOutput("release_preedge_valid", int'(bus6.square_q_valid), 0);
      @(posedge clk);
      #1;
      checkOutput("release_square_q", int'(bus6.square_q), 49);
      checkOutput("release_valid", int'(bus6.square_q_valid), 1);
      applyStimulus(6'd10);
      checkOutput("between_edges_square", int'(bus6.square), 100);
      checkOutput("between_edges_square_q", int'(bus6.square_q), 49);
      @(posedge clk);
      #1;
      checkOutput("next_edge_square_q", int'(bus6.square_q), 100);

      for (int v = 0; v < 256; v++) begin
         bus8.value = 8'(v);
         #1;
         checkOutput("w8_square", int'(bus8.square), v * v);
      end
      checkOutput("w8_max", int'(bus8.square), 65025);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/square_cal.md
SQUARE_CAL -- requirements
Module: square_cal

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, the bit width of the unsigned operand.
REQ-002 The block SHALL have parameter OWIDTH, default 2*WIDTH (12), the result width; it is not overridden independently.
REQ-003 Port clk, input, 1 bit, SHALL be the clock; all state updates occur on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-005 Port value, input, WIDTH bits, SHALL carry the unsigned operand.
REQ-006 Port square, output, OWIDTH bits, SHALL carry value*value, combinational.
REQ-007 Port square_q, output, OWIDTH bits, SHALL carry the registered copy of square.
REQ-008 Port square_q_valid, output, 1 bit, SHALL flag that square_q holds a result computed after reset release.

Function
REQ-009 square SHALL equal value*value exactly, unsigned, for every input 0..2^WIDTH-1, with zero-cycle latency (no clock dependency).
REQ-010 square SHALL never overflow: the maximum 63*63 = 3969 (0xF81) fits in 12 bits; upper result bits are zero-extended, never truncated.
REQ-011 square SHALL be built as an explicit partial-product array: row i = value gated by value[i], shifted left i, summed by ripple/carry-save adder rows; the HDL multiply operator SHALL NOT be used.
REQ-012 square SHALL have no latches, and square is not affected by clk or reset.
REQ-013 square_q SHALL load square on every rising clk edge while reset is high: square_q(n+1) = value(n)^2, one-cycle latency.
REQ-014 square_q_valid SHALL go to 1 on the first rising edge after reset deasserts and stay 1 until the next reset.
REQ-015 A change of value between clock edges SHALL affect square immediately and square_q only at the next edge.
REQ-016 Operand wrap (value 63 -> 0 from an incrementing source) SHALL produce 3969 then 0 with no special handling.

Reset
REQ-017 While reset is low, square_q SHALL be 0 and square_q_valid SHALL be 0, asynchronously, regardless of clk.
REQ-018 Reset asserted mid-operation SHALL clear square_q and square_q_valid immediately; square keeps tracking value.
REQ-019 Reset release SHALL be sampled synchronously: the first load of square_q happens on the first rising edge with reset high.

Structure
REQ-020 A shared package SHALL hold the WIDTH default (6), the OWIDTH derivation, and the constant MAX_SQUARE = 3969.
REQ-021 One sub-module, square_pp_row, SHALL implement one partial-product row (AND-gating plus OWIDTH-bit adder with carry); square_cal instantiates WIDTH-1 of them in a generate loop.
REQ-022 The output register stage (square_q, square_q_valid) SHALL reside in square_cal.

Verification
REQ-023 Set value=0 -> square=0; value=1 -> 1; value=2 -> 4, all checked same cycle.
REQ-024 Set value=63 -> square=3969 (0xF81); value=32 -> 1024 (0x400); value=45 -> 2025 (0x7E9).
REQ-025 Reset low for 14 time units, then 6-bit counter 0..63 on clk; at every edge square == counter^2, and after the edge square_q == previous counter^2; the file of 64 results SHALL hold 0,1,4,...,3969.
REQ-026 Counter wrap 63 -> 0 -> square 3969 then 0, and square_q follows one cycle later.
REQ-027 Assert reset mid-sweep between edges -> square_q=0 and square_q_valid=0 immediately; release -> valid=1 and correct square_q after the first edge.
REQ-028 Exhaustive sweep with WIDTH=8 -> square == value^2 for all 256 values, maximum 65025.
